// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/result bundle between the execute-stage control
// unit (master) and the iterative multiply/divide unit (slave).
interface alu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             div_zero;

  modport master (
    output start, op, A, B,
    input  busy, done, hi, lo, div_zero
  );

  modport slave (
    input  start, op, A, B,
    output busy, done, hi, lo, div_zero
  );
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative 32-bit MULT/MULTU/DIV/DIVU unit, one add/subtract
// per cycle over 32 CALC cycles, followed by a sign fix-up cycle.
// Define ALU_MULDIV_DIV_EN to build the restoring divider; without it,
// divide ops keep their timing but produce hi=lo=0 and div_zero=0.
module alu_muldiv (
  input  logic         clk,
  input  logic         reset,
  alu_muldiv_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic [31:0] opnd_q, opnd_d;     // |multiplicand| for mul, |divisor| for div
  logic [63:0] acc_q, acc_d;       // {upper, multiplier} or {rem, quot}
  logic        neg_q, neg_d;       // product/quotient must be negated
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        dz_q, dz_d;

  logic        signed_op;
  logic [31:0] mag_a, mag_b;
  logic [32:0] add_sum;
  logic [63:0] prod_fix;

`ifdef ALU_MULDIV_DIV_EN
  logic [31:0] a_q, a_d;           // original dividend, reported on divide by zero
  logic        rem_neg_q, rem_neg_d;
  logic        b_zero_q, b_zero_d;
  logic [32:0] div_trial;
  logic [31:0] quot_fix, rem_fix;
`endif

  // Operand magnitudes: only signed ops (op[0]==0) take absolute values.
  assign signed_op = ~bus.op[0];
  assign mag_a     = (signed_op && bus.A[31]) ? -bus.A : bus.A;
  assign mag_b     = (signed_op && bus.B[31]) ? -bus.B : bus.B;

  // Shift-add step keeps the carry in bit 32 so the right shift never loses it.
  assign add_sum  = {1'b0, acc_q[63:32]} + {1'b0, opnd_q};
  assign prod_fix = neg_q ? -acc_q : acc_q;

`ifdef ALU_MULDIV_DIV_EN
  // Restoring step on the left-shifted {rem, quot}; bit 32 set means negative.
  assign div_trial = {1'b0, acc_q[62:31]} - {1'b0, opnd_q};
  assign quot_fix  = neg_q     ? -acc_q[31:0]  : acc_q[31:0];
  assign rem_fix   = rem_neg_q ? -acc_q[63:32] : acc_q[63:32];
`endif

  // Next-state and datapath update for the IDLE/CALC/FIX/DONE sequence.
  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case
    // can leave a signal unassigned and infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
`ifdef ALU_MULDIV_DIV_EN
    a_d       = a_q;
    rem_neg_d = rem_neg_q;
    b_zero_d  = b_zero_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          is_div_d = bus.op[1];
          cnt_d    = 5'd0;
          neg_d    = signed_op & (bus.A[31] ^ bus.B[31]);
          if (bus.op[1]) begin
            opnd_d = mag_b;
            acc_d  = {32'd0, mag_a};
          end else begin
            opnd_d = mag_a;
            acc_d  = {32'd0, mag_b};
          end
`ifdef ALU_MULDIV_DIV_EN
          a_d       = bus.A;
          rem_neg_d = signed_op & bus.A[31];
          b_zero_d  = (bus.B == 32'd0);
`endif
          state_d = CALC;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end

      CALC: begin
        cnt_d = cnt_q + 5'd1;
        if (!is_div_q) begin
          if (acc_q[0]) acc_d = {add_sum, acc_q[31:1]};
          else          acc_d = {1'b0, acc_q[63:1]};
        end
`ifdef ALU_MULDIV_DIV_EN
        else begin
          if (!div_trial[32]) acc_d = {div_trial[31:0], acc_q[30:0], 1'b1};
          else                acc_d = {acc_q[62:0], 1'b0};
        end
`endif
        if (cnt_q == 5'd31) state_d = FIX;
      end

      FIX: begin
        if (!is_div_q) begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
          dz_d = 1'b0;
        end else begin
`ifdef ALU_MULDIV_DIV_EN
          if (b_zero_q) begin
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
            dz_d = 1'b1;
          end else begin
            hi_d = rem_fix;
            lo_d = quot_fix;
            dz_d = 1'b0;
          end
`else
          hi_d = 32'd0;
          lo_d = 32'd0;
          dz_d = 1'b0;
`endif
        end
        state_d = DONE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      neg_q    <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      dz_q     <= 1'b0;
`ifdef ALU_MULDIV_DIV_EN
      a_q       <= 32'd0;
      rem_neg_q <= 1'b0;
      b_zero_q  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values.
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
`ifdef ALU_MULDIV_DIV_EN
      a_q       <= a_d;
      rem_neg_q <= rem_neg_d;
      b_zero_q  <= b_zero_d;
`endif
    end
  end

  assign bus.busy     = (state_q == CALC) || (state_q == FIX);
  assign bus.done     = (state_q == DONE);
  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed plus random ops against an arithmetic reference
// model; also covers busy-ignore, back-to-back issue and reset mid-op.
module tb_alu_muldiv;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_muldiv_if bus ();

  alu_muldiv dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  logic        exp_dz = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference results straight from 64-bit integer arithmetic.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    hi = 32'd0;
    lo = 32'd0;
    dz = 1'b0;
    case (op)
      2'b00: begin r = sa * sb; hi = r[63:32]; lo = r[31:0]; end
      2'b01: begin r = ua * ub; hi = r[63:32]; lo = r[31:0]; end
      default: begin
`ifdef ALU_MULDIV_DIV_EN
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
          dz = 1'b1;
        end else if (op == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          r  = sq;
          lo = r[31:0];
          r  = sr;
          hi = r[31:0];
        end else begin
          uq = ua / ub;
          ur = ua % ub;
          r  = uq;
          lo = r[31:0];
          r  = ur;
          hi = r[31:0];
        end
`endif
      end
    endcase
  endfunction

  // Drive a request for the next edge; operands are scrambled right after.
  task automatic accept(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.A     = a;
    bus.B     = b;
    model(op, a, b, exp_hi, exp_lo, exp_dz);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.op    = 2'($urandom_range(0, 3));
    bus.A     = $urandom;
    bus.B     = $urandom;
    check("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    check("done_after_accept", {31'd0, bus.done}, 32'd0);
  endtask

  // Wait (bounded) for done, optionally pulsing start while busy.
  task automatic complete(input bit noise);
    int n = 0;
    while (n < 40 && !bus.done) begin
      if (noise && n == 5) begin
        bus.start = 1'b1;
        bus.op    = 2'($urandom_range(0, 3));
        bus.A     = $urandom;
        bus.B     = $urandom | 32'd1;
      end
      if (noise && n == 6) bus.start = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check("latency", n, 33);
    check("hi", bus.hi, exp_hi);
    check("lo", bus.lo, exp_lo);
    check("div_zero", {31'd0, bus.div_zero}, {31'd0, exp_dz});
    check("busy_in_done", {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic idle_check();
    @(posedge clk);
    #1;
    check("done_cleared", {31'd0, bus.done}, 32'd0);
    check("busy_idle", {31'd0, bus.busy}, 32'd0);
    check("hi_hold", bus.hi, exp_hi);
    check("lo_hold", bus.lo, exp_lo);
  endtask

  task automatic run(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    accept(op, a, b);
    complete(1'b0);
    idle_check();
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_dz", {31'd0, bus.div_zero}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Unsigned and signed multiply with known answers.
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
    check("multu_max_lo", bus.lo, 32'h0000_0001);
    run(2'b00, 32'hFFFF_FFFD, 32'd5);
    check("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", bus.lo, 32'hFFFF_FFF1);

    // Signed divide, overflow corner, divide by zero then clearing multiply.
    run(2'b10, 32'hFFFF_FFF9, 32'd2);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b11, 32'd100, 32'd0);
    run(2'b01, 32'd2, 32'd3);
    check("multu_small_lo", bus.lo, 32'd6);
    run(2'b10, 32'd9, 32'd3);

    // start pulsed while busy must not disturb the first operation.
    accept(2'b00, 32'h1234_5678, 32'hFEDC_BA98);
    complete(1'b1);
    idle_check();

    // start held in DONE: second op accepted at the next edge.
    accept(2'b01, 32'h0001_0000, 32'h0001_0000);
    complete(1'b0);
    accept(2'b11, 32'hDEAD_BEEF, 32'd13);
    complete(1'b0);
    idle_check();

    // Reset ten cycles into a divide.
    accept(2'b11, 32'd1000, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_hi", bus.hi, 32'd0);
    check("midrst_lo", bus.lo, 32'd0);
    check("midrst_dz", {31'd0, bus.div_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    run(2'b11, 32'd1000, 32'd7);

    // Random mix, with small and zero divisors sprinkled in.
    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      run(rop, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
